// File: rtl/risc_sequencer_if.sv
// rtl/risc_sequencer_if.sv - control/strobe bundle between the sequencer and the accumulator-core datapath
interface risc_sequencer_if;
  // datapath -> sequencer
  logic [2:0] opcode;  // IR[7:5]; meaningful from phase 4 onward
  logic       zero;    // accumulator == 0
  logic       stall;   // slow memory: hold the current phase

  // sequencer -> datapath
  logic       sel;     // address mux: 1 = PC, 0 = IR operand
  logic       rd;
  logic       ld_ir;
  logic       inc_pc;
  logic       ld_pc;
  logic       ld_ac;
  logic       wr;
  logic       data_e;
  logic       halt;
  logic [2:0] phase;

  // sequencer side
  modport master (
    input  opcode, zero, stall,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
  );

  // datapath side
  modport slave (
    output opcode, zero, stall,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
  );
endinterface

// File: rtl/risc_sequencer.sv
// rtl/risc_sequencer.sv - eight-phase fetch/decode/execute sequencer for the 8-bit accumulator core
module risc_sequencer #(
  parameter bit HALT_STICKY = 1'b1  // 1: halt latches until reset; 0: halt only flags phase 4
) (
  input  logic             clk,
  input  logic             rst,  // asynchronous, active low
  risc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_e     r_phase;
  phase_e     w_phase_nxt;
  logic       r_halted;
  logic       w_halted_nxt;
  logic [2:0] w_phase_inc;

  // raw phase/opcode decode before halt and stall gating
  logic w_sel, w_rd, w_ld_ir, w_inc_pc, w_ld_pc, w_ld_ac, w_wr, w_data_e, w_halt;
  logic w_aluop, w_is_hlt, w_is_skz, w_is_sto, w_is_jmp;

  assign w_phase_inc = r_phase + 3'd1;

  assign w_is_hlt = (bus.opcode == OP_HLT);
  assign w_is_skz = (bus.opcode == OP_SKZ);
  assign w_is_sto = (bus.opcode == OP_STO);
  assign w_is_jmp = (bus.opcode == OP_JMP);
  assign w_aluop  = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                    (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

  // phase and halted-flag state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase  <= PH_INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // next phase: advance unless halted or stalled; a sticky HLT freezes at phase 4
  always_comb begin
    w_phase_nxt  = r_phase;
    w_halted_nxt = r_halted;
    if (!r_halted && !bus.stall) begin
      if (HALT_STICKY && (r_phase == PH_OP_ADDR) && w_is_hlt) begin
        w_halted_nxt = 1'b1;
      end else begin
        w_phase_nxt = phase_e'(w_phase_inc);
      end
    end
  end

  // strobe decode from phase, opcode and zero
  always_comb begin
    w_sel    = 1'b0;
    w_rd     = 1'b0;
    w_ld_ir  = 1'b0;
    w_inc_pc = 1'b0;
    w_ld_pc  = 1'b0;
    w_ld_ac  = 1'b0;
    w_wr     = 1'b0;
    w_data_e = 1'b0;
    w_halt   = 1'b0;
    case (r_phase)
      PH_INST_ADDR: begin
        w_sel = 1'b1;
      end
      PH_INST_FETCH: begin
        w_sel = 1'b1;
        w_rd  = 1'b1;
      end
      PH_INST_LOAD, PH_IDLE: begin
        w_sel   = 1'b1;
        w_rd    = 1'b1;
        w_ld_ir = 1'b1;
      end
      PH_OP_ADDR: begin
        w_inc_pc = 1'b1;
        w_halt   = w_is_hlt;
      end
      PH_OP_FETCH: begin
        w_rd = w_aluop;
      end
      PH_ALU_OP: begin
        // zero reflects the accumulator from before this instruction
        w_rd     = w_aluop;
        w_inc_pc = w_is_skz && bus.zero;
        w_ld_pc  = w_is_jmp;
        w_data_e = w_is_sto;
      end
      PH_STORE: begin
        w_rd     = w_aluop;
        w_ld_ac  = w_aluop;
        w_ld_pc  = w_is_jmp;
        w_wr     = w_is_sto;
        w_data_e = w_is_sto;
      end
      default: begin
        w_sel = 1'b0;
      end
    endcase
  end

  // halted overrides everything; stall only masks the once-per-phase side effects
  always_comb begin
    bus.sel    = w_sel;
    bus.rd     = w_rd;
    bus.ld_ir  = w_ld_ir;
    bus.inc_pc = w_inc_pc && !bus.stall;
    bus.ld_pc  = w_ld_pc;
    bus.ld_ac  = w_ld_ac;
    bus.wr     = w_wr && !bus.stall;
    bus.data_e = w_data_e;
    bus.halt   = w_halt;
    if (r_halted) begin
      bus.sel    = 1'b0;
      bus.rd     = 1'b0;
      bus.ld_ir  = 1'b0;
      bus.inc_pc = 1'b0;
      bus.ld_pc  = 1'b0;
      bus.ld_ac  = 1'b0;
      bus.wr     = 1'b0;
      bus.data_e = 1'b0;
      bus.halt   = 1'b1;
    end
  end

  assign bus.phase = r_phase;

endmodule

// File: tb/tb_risc_sequencer.sv
// tb/tb_risc_sequencer.sv - table-driven and hand-sequenced checks for risc_sequencer
`timescale 1ns/1ps
module tb_risc_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   inc_cnt;
  int   wr_cnt;
  int   cyc;

  risc_sequencer_if bus ();

  risc_sequencer #(.HALT_STICKY(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packed strobe order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
  typedef struct {
    logic [2:0]       op;
    logic             z;
    logic [7:0][8:0]  exp;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [8:0] strobes();
    return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
            bus.ld_ac, bus.wr, bus.data_e, bus.halt};
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic z,
                              input logic [8:0] p5, input logic [8:0] p6,
                              input logic [8:0] p7);
    vec_t v;
    v.op  = op;
    v.z   = z;
    v.exp = {p7, p6, p5, 9'b000100000, 9'b111000000, 9'b111000000,
             9'b110000000, 9'b100000000};
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // one clock; counts the inc_pc/wr values that the edge acts on
  task automatic tick();
    inc_cnt += int'(bus.inc_pc);
    wr_cnt  += int'(bus.wr);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    inc_cnt   = 0;
    wr_cnt    = 0;
    cyc       = 0;
    rst       = 1'b1;
    bus.opcode = 3'd0;
    bus.zero   = 1'b0;
    bus.stall  = 1'b0;

    vecs[0] = mk(3'd7, 1'b0, 9'b000000000, 9'b000010000, 9'b000010000); // JMP
    vecs[1] = mk(3'd1, 1'b1, 9'b000000000, 9'b000100000, 9'b000000000); // SKZ z=1
    vecs[2] = mk(3'd1, 1'b0, 9'b000000000, 9'b000000000, 9'b000000000); // SKZ z=0
    vecs[3] = mk(3'd6, 1'b0, 9'b000000000, 9'b000000010, 9'b000000110); // STO
    vecs[4] = mk(3'd2, 1'b1, 9'b010000000, 9'b010000000, 9'b010001000); // ADD
    vecs[5] = mk(3'd3, 1'b0, 9'b010000000, 9'b010000000, 9'b010001000); // AND
    vecs[6] = mk(3'd4, 1'b0, 9'b010000000, 9'b010000000, 9'b010001000); // XOR
    vecs[7] = mk(3'd5, 1'b1, 9'b010000000, 9'b010000000, 9'b010001000); // LDA

    // ---- table-driven: every phase of one instruction, twice around ----
    for (int i = 0; i < 8; i++) begin
      bus.opcode = vecs[i].op;
      bus.zero   = vecs[i].z;
      do_reset();
      for (int rep = 0; rep < 2; rep++) begin
        for (int p = 0; p < 8; p++) begin
          chk($sformatf("vec%0d_phase_p%0d", i, p), int'(bus.phase), p);
          chk($sformatf("vec%0d_strobes_p%0d", i, p), int'(strobes()), int'(vecs[i].exp[p]));
          tick();
        end
      end
      chk($sformatf("vec%0d_wrap", i), int'(bus.phase), 0);
    end

    // ---- HLT: sticky halt, stall ignored, reset releases ----
    bus.opcode = 3'd0;
    bus.zero   = 1'b0;
    do_reset();
    chk("hlt_reset_sel", int'(bus.sel), 1);
    chk("hlt_reset_halt", int'(bus.halt), 0);
    chk("hlt_reset_strobes", int'(strobes()), 9'b100000000);
    for (int k = 0; k < 4; k++) tick();
    chk("hlt_p4_phase", int'(bus.phase), 4);
    chk("hlt_p4_halt", int'(bus.halt), 1);
    chk("hlt_p4_inc", int'(bus.inc_pc), 1);
    for (int k = 0; k < 20; k++) tick();
    chk("hlt_frozen_phase", int'(bus.phase), 4);
    chk("hlt_frozen_strobes", int'(strobes()), 9'b000000001);
    bus.stall = 1'b1;
    tick();
    bus.stall = 1'b0;
    bus.opcode = 3'd2;
    tick();
    chk("hlt_stall_opchg_phase", int'(bus.phase), 4);
    chk("hlt_stall_opchg_strobes", int'(strobes()), 9'b000000001);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("hlt_rst_halt", int'(bus.halt), 0);
    chk("hlt_rst_phase", int'(bus.phase), 0);
    chk("hlt_rst_sel", int'(bus.sel), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    chk("hlt_restart_phase", int'(bus.phase), 1);

    // ---- STO with 3-clock stalls in phase 4 and phase 7 ----
    bus.opcode = 3'd6;
    do_reset();
    inc_cnt = 0;
    wr_cnt  = 0;
    cyc     = 0;
    for (int k = 0; k < 4; k++) tick();
    chk("stall_p4_inc_before", int'(bus.inc_pc), 1);
    bus.stall = 1'b1;
    #1;
    chk("stall_p4_inc_masked", int'(bus.inc_pc), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_p4_hold%0d", k), int'(bus.phase), 4);
      chk($sformatf("stall_p4_inc%0d", k), int'(bus.inc_pc), 0);
    end
    bus.stall = 1'b0;
    #1;
    tick();
    chk("stall_p5", int'(bus.phase), 5);
    tick();
    tick();
    chk("stall_p7", int'(bus.phase), 7);
    bus.stall = 1'b1;
    #1;
    chk("stall_p7_wr_masked", int'(bus.wr), 0);
    chk("stall_p7_data_e", int'(bus.data_e), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_p7_hold%0d", k), int'(bus.phase), 7);
      chk($sformatf("stall_p7_wr%0d", k), int'(bus.wr), 0);
    end
    bus.stall = 1'b0;
    #1;
    chk("stall_p7_wr_release", int'(bus.wr), 1);
    tick();
    chk("stall_end_phase", int'(bus.phase), 0);
    chk("stall_clocks", cyc, 14);
    chk("stall_inc_pulses", inc_cnt, 1);
    chk("stall_wr_pulses", wr_cnt, 1);

    // ---- asynchronous reset in the middle of phase 7 STO ----
    bus.opcode = 3'd6;
    do_reset();
    for (int k = 0; k < 7; k++) tick();
    chk("rst7_phase", int'(bus.phase), 7);
    chk("rst7_wr_before", int'(bus.wr), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst7_wr_dropped", int'(bus.wr), 0);
    chk("rst7_phase0", int'(bus.phase), 0);
    chk("rst7_strobes", int'(strobes()), 9'b100000000);
    @(posedge clk);
    #1;
    chk("rst7_held_strobes", int'(strobes()), 9'b100000000);
    rst = 1'b1;
    tick();
    chk("rst7_restart_phase", int'(bus.phase), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/risc_sequencer.md
Name: risc_sequencer

Overview:
- Eight-phase control sequencer for the 8-bit accumulator RISC core.
- Instruction format: 3-bit opcode and 5-bit address into the 32-word memory.
- Steps a phase counter through fetch, decode and execute for every instruction, and decodes the datapath strobes from the phase, the IR opcode and the accumulator-zero flag.
- Drives the PC, IR, ACC, memory and address mux.
- Also owns the sticky halt and a stall hook for slow memory.

Parameters:
- HALT_STICKY, 1, 1 = halt latches until reset; 0 = halt asserted only in phase 4, and the sequencer continues.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- opcode  in  3  IR[7:5]; valid from phase 4 onward. Encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- zero  in  1  accumulator == 0.
- stall  in  1  hold the current phase; no advance.
- sel  out  1  address mux: 1 = PC, 0 = IR operand.
- rd  out  1  memory read enable.
- ld_ir  out  1  load IR from the data bus.
- inc_pc  out  1  PC <= PC+1 (wraps 31 -> 0, datapath modulo 32).
- ld_pc  out  1  PC <= IR[4:0].
- ld_ac  out  1  load ACC from the ALU.
- wr  out  1  memory write strobe.
- data_e  out  1  ACC drives the data bus.
- halt  out  1  processor halted.
- phase  out  3  current phase, for debug and the bench.

Behaviour:
- State: 3-bit phase register, 0..7, plus a halted flag. Both are cleared asynchronously when rst=0.
- Reset values:
  - phase=0, halted=0.
  - sel=1; rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e and halt are all 0.
- Advance rule:
  - Each rising clk with rst=1, stall=0 and halted=0: phase <= phase+1; 7 wraps to 0.
  - Exactly 8 clocks per instruction when there is no stall.
- Outputs are combinational from (phase, opcode, zero, halted); no added latency. Define aluop = ADD|AND|XOR|LDA.
  - Phase 0 INST_ADDR: sel=1.
  - Phase 1 INST_FETCH: sel=1, rd=1.
  - Phase 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - Phase 3 IDLE: sel=1, rd=1, ld_ir=1.
  - Phase 4 OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - Phase 5 OP_FETCH: rd=aluop.
  - Phase 6 ALU_OP:
    - rd=aluop.
    - inc_pc=(opcode==SKZ && zero).
    - ld_pc=(opcode==JMP).
    - data_e=(opcode==STO).
  - Phase 7 STORE:
    - rd=aluop, ld_ac=aluop.
    - ld_pc=(opcode==JMP).
    - wr=(opcode==STO), data_e=(opcode==STO).
  - Any signal not listed for a phase is 0.
- Halt:
  - On the clock edge leaving phase 4 with opcode==HLT and HALT_STICKY=1: halted <= 1 and phase freezes at 4.
  - While halted:
    - halt=1.
    - inc_pc is forced to 0, so the PC is not bumped again.
    - All other strobes are 0.
    - stall is ignored.
  - Only rst clears the halt.
- Stall:
  - phase holds and outputs keep their decoded values; the datapath must tolerate repeated ld_ir and rd.
  - inc_pc is suppressed while stall=1, so the PC is incremented only once per phase occurrence.
  - wr is likewise suppressed while stall=1.
- zero is sampled combinationally in phase 6 only. The ACC does not change before the end of phase 7, so SKZ uses the pre-instruction accumulator.
- Reset mid-instruction: outputs return to their reset values in the same cycle, with no partial wr or ld_pc afterward.
- Simultaneous events:
  - rst overrides everything.
  - halted overrides stall.
  - phase is unaffected by opcode changes in phases 0-3.

Test Plan:
- Reset, opcode=HLT: sel=1 and halt=0 after reset. After 4 clocks, phase=4 and halt=1. After 20 further clocks, halt=1, phase=4 and inc_pc=0.
- opcode=JMP: ld_pc=1 exactly in phases 6 and 7; inc_pc=1 only in phase 4. Phase sequence 0..7,0 repeats every 8 clocks.
- opcode=SKZ with zero=1: inc_pc high in phases 4 and 6. With zero=0: inc_pc high in phase 4 only.
- opcode=STO: data_e=1 in phases 6-7, wr=1 only in phase 7, rd=0 in phases 5-7. For opcode=ADD: rd=1 in phases 5-7, ld_ac=1 in phase 7 only.
- Assert stall for 3 clocks in phase 4 and in phase 7 with opcode=STO: phase holds, inc_pc and wr stay 0 while stalled, and each pulses exactly once after release. The instruction takes 14 clocks total.
- Drive rst=0 asynchronously mid-phase 7 with opcode=STO: wr drops immediately, and phase=0, sel=1 before the next edge. Drive rst=0 while halted: halt clears and execution restarts at phase 0.
